bist_sig_analyzer: RTL
======================

BIST_SIG_ANALYZER -- requirements
Module: bist_sig_analyzer

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel lane; legal range 2 to 32.
REQ-002 Parameter CHANNELS, default 4: number of independent MISR lanes; legal range 1 to 16.
REQ-003 Parameter TAPS [WIDTH-1:0], default 8'hB8: feedback tap mask, shared by all lanes.
REQ-004 Parameter SEED [WIDTH-1:0], default 8'h00: lane value loaded on reset and on start.
REQ-005 Parameter WARMUP, default 17: number of valid samples discarded before compaction; 0 is legal.
REQ-006 Parameter LEN_W, default 16: width of the sample-length input.
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-010 abort  input  1  forces a return to IDLE from any state.
REQ-011 sample_len  input  LEN_W  number of valid samples to compact; captured on an accepted start.
REQ-012 data_valid  input  1  qualifies data_in in the current cycle.
REQ-013 data_in  input  CHANNELS*WIDTH  lane k uses bits [k*WIDTH +: WIDTH].
REQ-014 golden  input  CHANNELS*WIDTH  expected signature; sampled on the cycle the block enters DONE.
REQ-015 signature  output  CHANNELS*WIDTH  current lane registers, concatenated in the same order as data_in.
REQ-016 busy  output  1  high in WARMUP and COMPACT.
REQ-017 done  output  1  high while in DONE.
REQ-018 pass  output  1  registered result of signature == golden; valid only while done is high.

Function
REQ-019 The FSM SHALL have four states: IDLE, WARMUP, COMPACT and DONE.
REQ-020 An accepted start SHALL load every lane with SEED, clear both counters and capture sample_len.
REQ-021 After an accepted start, the next state SHALL be WARMUP when WARMUP>0, otherwise COMPACT.
REQ-022 In WARMUP, each valid cycle SHALL increment the warm counter and the lanes SHALL hold.
REQ-023 In WARMUP, the valid cycle on which the count reaches WARMUP SHALL move the FSM to COMPACT.
REQ-024 In COMPACT, each valid cycle SHALL update every lane k as lane <= {lane[WIDTH-2:0], ^(lane & TAPS)} ^ data_in lane k, and SHALL increment the sample counter.
REQ-025 In COMPACT, invalid cycles SHALL leave the lanes and counters unchanged.
REQ-026 The valid cycle that completes sample_len samples SHALL update the lanes and then move the FSM to DONE.
REQ-027 On entry to DONE, pass SHALL register the comparison of the updated lanes against golden.
REQ-028 If sample_len==0, the block SHALL go straight to DONE wherever it would otherwise enter COMPACT, with signature equal to SEED in every lane.
REQ-029 DONE SHALL hold signature, done and pass until start, abort or rst occurs.
REQ-030 start in DONE SHALL be accepted and SHALL behave exactly as from IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort SHALL take priority over start and data_valid.
REQ-033 abort SHALL move the FSM to IDLE, clear done and pass, and hold signature.
REQ-034 The counters SHALL never wrap: the warm counter is $clog2(WARMUP+1) bits, and the sample counter is LEN_W bits compared for equality.

Reset
REQ-035 rst SHALL take priority over every other input.
REQ-036 On rst: state=IDLE, every lane=SEED, counters=0, busy=0, done=0, pass=0.
REQ-037 rst asserted mid-run SHALL discard the run with no partial done or pass.

Structure
REQ-038 Package bist_pkg SHALL hold the state enum bist_state_t and the default TAPS/SEED constants.
REQ-039 A sub-module misr_lane (WIDTH, TAPS, SEED; inputs load and shift_en) SHALL be instantiated CHANNELS times by generate.
REQ-040 The FSM and the counters SHALL reside in the top level only.

Verification (WIDTH=8, TAPS=8'hB8, SEED=0, CHANNELS=1 unless stated)
REQ-041 WARMUP=0, sample_len=3, data 01,00,00 -> signature 8'h04, done high the cycle after the 3rd valid, pass=1 with golden=04.
REQ-042 WARMUP=0, sample_len=2, data FF,00 -> signature 8'hFE; golden=FF -> pass=0.
REQ-043 WARMUP=17, 17 valid samples of junk then FF,00 with invalid gaps interleaved -> signature FE, busy high throughout the run.
REQ-044 CHANNELS=4, sample_len=1, data_in=32'h04030201 -> signature 32'h04030201; sample_len=0 -> signature 0 and done one cycle after start.
REQ-045 abort in mid-COMPACT -> IDLE next cycle, done=0, pass=0; start asserted while busy -> no effect.
REQ-046 rst asserted in COMPACT -> next cycle all outputs at reset values; start in DONE -> new run begins from SEED.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST signature analyzer.
// Holds the FSM state encoding, the default tap/seed constants and a width helper.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COMPACT,
    ST_DONE
  } bist_state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h00;

  // A zero-length warm-up still needs a one-bit counter to keep the port legal.
  function automatic int warm_width(input int warmup);
    return (warmup > 0) ? $clog2(warmup + 1) : 1;
  endfunction

endpackage

// File: rtl/misr_lane.sv
// One MISR lane: shift with tap-parity feedback, XOR in the lane's data word.
// Exposes both the registered value and its next value so the parent can compare early.
module misr_lane
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] lane_d,
  output logic [WIDTH-1:0] lane_q
);

  always_comb begin
    lane_d = lane_q;
    if (load) begin
      lane_d = SEED;
    end else if (shift_en) begin
      lane_d = {lane_q[WIDTH-2:0], ^(lane_q & TAPS)} ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= SEED;
    end else begin
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/bist_sig_analyzer.sv
// Multi-lane MISR signature analyzer with warm-up discard and golden compare.
// The FSM and both counters live here; each lane is a misr_lane instance.
module bist_sig_analyzer
  import bist_pkg::*;
#(
  parameter int                 WIDTH    = 8,
  parameter int                 CHANNELS = 4,
  parameter logic [WIDTH-1:0]   TAPS     = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0]   SEED     = WIDTH'(DEFAULT_SEED),
  parameter int                 WARMUP   = 17,
  parameter int                 LEN_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          sample_len,
  input  logic                      data_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS*WIDTH-1:0] golden,
  output logic [CHANNELS*WIDTH-1:0] signature,
  output logic                      busy,
  output logic                      done,
  output logic                      pass
);

  localparam int                WARM_W    = warm_width(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP);

  bist_state_t               state_q, state_d;
  logic [WARM_W-1:0]         warm_q, warm_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      start_ok;
  logic                      load;
  logic                      shift_en;
  logic                      match;
  logic [CHANNELS*WIDTH-1:0] sig_d;
  logic [CHANNELS*WIDTH-1:0] sig_q;

  // Lane controls are kept out of the FSM block so the compare below sees settled next values.
  assign start_ok = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign load     = start_ok;
  assign shift_en = !abort && (state_q == ST_COMPACT) && data_valid;
  assign match    = (sig_d == golden);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      misr_lane #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (data_in[gi*WIDTH +: WIDTH]),
        .lane_d   (sig_d[gi*WIDTH +: WIDTH]),
        .lane_q   (sig_q[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            warm_d = '0;
            cnt_d  = '0;
            len_d  = sample_len;
            done_d = 1'b0;
            pass_d = 1'b0;
            if (WARMUP > 0) begin
              state_d = ST_WARMUP;
            end else if (sample_len == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = match;
            end else begin
              state_d = ST_COMPACT;
            end
          end
        end
        ST_WARMUP: begin
          if (data_valid) begin
            warm_d = warm_q + 1'b1;
            if (warm_q + 1'b1 == WARM_LAST) begin
              if (len_q == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = match;
              end else begin
                state_d = ST_COMPACT;
              end
            end
          end
        end
        ST_COMPACT: begin
          if (data_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == len_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = match;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_WARMUP) || (state_d == ST_COMPACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule
